// File: rtl/jk_bank_ctrl_pkg.sv
// Purpose: shared types for the JK bank controller (opcodes, FSM states, JK actions).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jk_ctrl_pkg;

    // Command opcodes as carried on cmd_op.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SET    = 3'd2,
        OP_LOAD   = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_UP     = 3'd5,
        OP_DOWN   = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Per-cell JK action encoding, packed as {j, k}.
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Purpose: command channel into jk_bank_ctrl (valid/ready + op, data, step count).
// Latency: n/a (wiring only).
// Backpressure: cmd_ready from the slave; a command transfers when cmd_valid && cmd_ready.
// Ports: master drives cmd_valid/cmd_op/cmd_data/cmd_len, slave drives cmd_ready.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_ctrl_cell.sv
// Purpose: single JK flip-flop cell (00 hold, 01 reset, 10 set, 11 toggle).
// Latency: q updates on the rising edge following j/k.
// Backpressure: none.
// Ports: clk, reset (sync, active-high, q->0), j, k, q.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

// File: rtl/jk_bank_ctrl.sv
// Purpose: command-driven sequencer for a bank of WIDTH JK cells (clear/set/load/toggle/hold/count).
// Latency: single-step op updates q one edge after accept, done the cycle after; count of L steps ends at accept+L.
// Backpressure: cmd_ready only in IDLE; commands offered while busy wait at the source, nothing is buffered.
// Ports: clk, reset (sync, active-high), cmd (slave command channel), q (bank state), busy, done (1-cycle pulse).
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    jk_bank_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] tgl_up, tgl_dn;
    logic             accept;
    op_e              cmd_op;

    assign cmd_op        = op_e'(cmd.cmd_op);
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state_q == ST_EXEC) || (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down);
    // bit 0 has an empty lower range and so always toggles.
    always_comb begin
        logic all_one;
        logic all_zero;
        all_one  = 1'b1;
        all_zero = 1'b1;
        tgl_up   = '0;
        tgl_dn   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tgl_up[i] = all_one;
            tgl_dn[i] = all_zero;
            all_one   = all_one & q[i];
            all_zero  = all_zero & ~q[i];
        end
    end

    // Next state, latched command fields and per-cell JK actions.
    always_comb begin
        logic [1:0] act;
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        j       = '0;
        k       = '0;
        act     = HOLD;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    data_d = cmd.cmd_data;
                    cnt_d  = cmd.cmd_len;
                    if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
                        // A zero-length count completes without touching q.
                        state_d = (cmd.cmd_len == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                for (int i = 0; i < WIDTH; i++) begin
                    case (op_q)
                        OP_CLEAR:  act = RST;
                        OP_SET:    act = SET;
                        OP_LOAD:   act = data_q[i] ? SET : RST;
                        OP_TOGGLE: act = data_q[i] ? TGL : HOLD;
                        default:   act = HOLD;  // HOLD and the reserved opcode
                    endcase
                    j[i] = act[1];
                    k[i] = act[0];
                end
                state_d = ST_DONE;
            end

            ST_RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (op_q == OP_UP) begin
                        act = tgl_up[i] ? TGL : HOLD;
                    end else begin
                        act = tgl_dn[i] ? TGL : HOLD;
                    end
                    j[i] = act[1];
                    k[i] = act[0];
                end
                cnt_d = cnt_q - CNT_W'(1);
                // cnt_q == 1 means this cycle performs the last step.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Purpose: directed self-checking bench for jk_bank_ctrl.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercises a command held on the channel while a count runs.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    jk_bank_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if.slave),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command for one edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [7:0] len);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_len   = len;
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
    endtask

    // Single-step op: EXEC for one cycle, DONE for one cycle, then IDLE.
    task automatic run_single(input string tag, input logic [2:0] op, input logic [7:0] data,
                              input logic [7:0] exp_q);
        issue(op, data, 8'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_rdy_in_done"}, {31'd0, cmd_if.cmd_ready}, 32'd0);
        tick();
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check({tag, "_rdy"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_data  = 8'h00;
        cmd_if.cmd_len   = 8'h00;
        reset            = 1'b1;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_q", {24'd0, q}, 32'h00);

        // LOAD then TOGGLE low nibble.
        run_single("load_a5", 3'd3, 8'hA5, 8'hA5);
        run_single("tgl_0f", 3'd4, 8'h0F, 8'hAA);

        // COUNT_UP wrap: FE -> FF -> 00 -> 01.
        run_single("load_fe", 3'd3, 8'hFE, 8'hFE);
        issue(3'd5, 8'h00, 8'd3);
        check("up_b0", {31'd0, busy}, 32'd1);
        check("up_q0", {24'd0, q}, 32'hFE);
        tick();
        check("up_q1", {24'd0, q}, 32'hFF);
        check("up_b1", {31'd0, busy}, 32'd1);
        tick();
        check("up_q2", {24'd0, q}, 32'h00);
        check("up_b2", {31'd0, busy}, 32'd1);
        tick();
        check("up_q3", {24'd0, q}, 32'h01);
        check("up_b3", {31'd0, busy}, 32'd0);
        check("up_done", {31'd0, done}, 32'd1);
        tick();
        check("up_done_clr", {31'd0, done}, 32'd0);
        check("up_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);

        // Zero-length COUNT_DOWN leaves q alone and completes immediately.
        run_single("load_10", 3'd3, 8'h10, 8'h10);
        issue(3'd6, 8'h00, 8'd0);
        check("dn0_done", {31'd0, done}, 32'd1);
        check("dn0_busy", {31'd0, busy}, 32'd0);
        check("dn0_q", {24'd0, q}, 32'h10);
        tick();
        check("dn0_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("dn0_q_hold", {24'd0, q}, 32'h10);

        // COUNT_DOWN len 2 from 01: 00 then FF.
        run_single("load_01", 3'd3, 8'h01, 8'h01);
        issue(3'd6, 8'h00, 8'd2);
        check("dn2_busy", {31'd0, busy}, 32'd1);
        tick();
        check("dn2_q1", {24'd0, q}, 32'h00);
        tick();
        check("dn2_q2", {24'd0, q}, 32'hFF);
        check("dn2_done", {31'd0, done}, 32'd1);
        tick();

        // Backpressure: LOAD 3C held while COUNT_UP len 5 runs from FF.
        issue(3'd5, 8'h00, 8'd5);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd3;
        cmd_if.cmd_data  = 8'h3C;
        for (int s = 1; s <= 4; s++) begin
            tick();
            check("bp_step_q", {24'd0, q}, 32'(s - 1));
            check("bp_rdy_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
        end
        tick();
        check("bp_final_q", {24'd0, q}, 32'h04);
        check("bp_done", {31'd0, done}, 32'd1);
        tick();
        check("bp_idle_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("bp_idle_q", {24'd0, q}, 32'h04);
        tick();
        check("bp_load_busy", {31'd0, busy}, 32'd1);
        cmd_if.cmd_valid = 1'b0;
        tick();
        check("bp_load_q", {24'd0, q}, 32'h3C);
        check("bp_load_done", {31'd0, done}, 32'd1);
        tick();
        tick();
        check("bp_once_busy", {31'd0, busy}, 32'd0);
        check("bp_once_q", {24'd0, q}, 32'h3C);

        // Mid-run reset after 4 of 10 steps from 3C.
        issue(3'd5, 8'h00, 8'd10);
        for (int s = 0; s < 4; s++) tick();
        check("mr_q4", {24'd0, q}, 32'h40);
        check("mr_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("mr_rst_q", {24'd0, q}, 32'h00);
        check("mr_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("mr_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);
        for (int s = 0; s < 3; s++) begin
            check("mr_no_done", {31'd0, done}, 32'd0);
            check("mr_q_zero", {24'd0, q}, 32'h00);
            tick();
        end

        // SET, reserved op, HOLD, CLEAR.
        run_single("set", 3'd2, 8'h00, 8'hFF);
        run_single("rsvd", 3'd7, 8'h5A, 8'hFF);
        run_single("load_69", 3'd3, 8'h69, 8'h69);
        run_single("hold", 3'd0, 8'hFF, 8'h69);
        run_single("clear", 3'd1, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
Command-driven controller that sequences a bank of WIDTH JK flip-flop cells by computing their J/K inputs each cycle. It supports clear, set, load, masked toggle, hold, and multi-step up/down counting. Commands arrive over a valid/ready handshake, and completion is flagged with a one-cycle done pulse. It is the block the datapath uses instead of driving JK cells directly.

Parameters:
WIDTH, 8, number of JK cells in the bank (≥2)
CNT_W, 8, width of the step-count field for count commands

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  3  operation code (see Behaviour)
cmd_data  input  WIDTH  load value or toggle mask
cmd_len  input  CNT_W  number of count steps (count ops only)
q  output  WIDTH  current bank state (JK cell outputs)
busy  output  1  command in progress
done  output  1  one-cycle pulse when command completes

Behaviour:
- Clocking and reset: one clock (clk), synchronous active-high reset. Reset forces q=0, FSM=IDLE, busy=0, done=0, cmd_ready=1, and clears all latched command fields.
- Opcodes:
  - 0 HOLD: J=K=0.
  - 1 CLEAR: J=0, K=1 on all bits.
  - 2 SET: J=1, K=0 on all bits.
  - 3 LOAD: J=data, K=~data.
  - 4 TOGGLE: J=K=mask.
  - 5 COUNT_UP: J[i]=K[i]=&q[i-1:0], bit0 always toggles.
  - 6 COUNT_DOWN: J[i]=K[i]=&~q[i-1:0], bit0 always toggles.
  - 7 reserved, executes as HOLD.
- J/K when not executing: J=K=0 in every state except EXEC/RUN, so q holds.
- Command acceptance: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. op, data and len are latched at acceptance; inputs are ignored afterwards.
- FSM states: IDLE, EXEC, RUN, DONE.
  - IDLE → EXEC on accept of ops 0–4 or 7.
  - IDLE → RUN on accept of op 5/6 with len≠0.
  - IDLE → DONE on accept of op 5/6 with len=0 (q unchanged).
  - EXEC (1 cycle): J/K driven, q updates at the closing edge, → DONE.
  - RUN: one count step per cycle; down-counter is loaded with len and decremented each step; → DONE after the len-th step.
  - DONE (1 cycle): done=1, busy=0, cmd_ready=0, → IDLE.
- busy: 1 in EXEC and RUN.
- Latency: single-step op accepted at edge T0 → q updated at T1 → done high in cycle T1–T2 → ready again after T2. Count op with len=L → q final at T0+L, done in the following cycle.
- Wrap-around: modular. Up from all-ones gives 0; down from 0 gives all-ones; counting continues across the wrap.
- Reset mid-operation: the command is aborted, q=0, no done pulse, cmd_ready=1 in the cycle after reset deasserts.
- Backpressure: cmd_valid held while busy is not accepted and not queued (no buffering).

Decomposition:
- Package jk_ctrl_pkg holds:
  - op enum: OP_HOLD, OP_CLEAR, OP_SET, OP_LOAD, OP_TOGGLE, OP_UP, OP_DOWN, OP_RSVD
  - FSM state enum
  - JK action constants: HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11
- Sub-module jk_cell: a single JK flip-flop with ports clk, reset, j, k, q.
  - Standard JK truth table: 00 hold, 01 reset, 10 set, 11 toggle.
  - Synchronous reset to q=0.
  - Instantiated WIDTH times in a generate loop.
- The controller owns only the FSM, the step counter, and the J/K generation logic.

Test Plan:
- Reset: assert reset 2 cycles → q=0x00, cmd_ready=1, busy=0, done=0.
- LOAD: op=3, data=0xA5 → q=0xA5 one edge after accept; done high for exactly 1 cycle; cmd_ready=1 after. Then TOGGLE, mask=0x0F → q=0xAA.
- COUNT_UP wrap: from q=0xFE, op=5, len=3 → q sequence 0xFF, 0x00, 0x01 on consecutive edges; busy=1 for 3 cycles, then a done pulse.
- Zero-length count: COUNT_DOWN, len=0, from q=0x10 → q stays 0x10, done in the cycle after accept. Then COUNT_DOWN, len=2, from 0x01 → q=0x00 then 0xFF.
- Backpressure: hold cmd_valid with a LOAD during a running COUNT_UP, len=5 → LOAD not accepted until IDLE; it then executes once.
- Mid-run reset: reset during COUNT_UP, len=10, after 4 steps → q=0, no done pulse, cmd_ready=1 after reset drops. CLEAR/SET then give 0x00/0xFF, and op=7 leaves q unchanged.
